// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: state codes, opcode/funct
// values, datapath mux encodings and the packed control word.
package mips_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH    = 4'd0;
    localparam state_t ST_DECODE   = 4'd1;
    localparam state_t ST_MEMADR   = 4'd2;
    localparam state_t ST_MEMRD    = 4'd3;
    localparam state_t ST_MEMWB    = 4'd4;
    localparam state_t ST_MEMWR    = 4'd5;
    localparam state_t ST_RTEXEC   = 4'd6;
    localparam state_t ST_ALUWB    = 4'd7;
    localparam state_t ST_BRANCH   = 4'd8;
    localparam state_t ST_ADDIEXEC = 4'd9;
    localparam state_t ST_ADDIWB   = 4'd10;
    localparam state_t ST_JUMP     = 4'd11;
    localparam state_t ST_MULDIV   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_DIV   = 6'b011010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] MEMW_NONE = 2'b00;
    localparam logic [1:0] MEMW_WORD = 2'b11;

    typedef struct packed {
        logic       pcen;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] memwrite;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       md_busy;
    } ctrl_t;

    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] funct);
        return (op == OP_RTYPE) && ((funct == FN_MULT) || (funct == FN_DIV));
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational control-word decode for each controller state. FETCH requests
// irwrite/pcen unconditionally; the top qualifies them with memory completion.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.irwrite = 1'b1;
                ctrl.pcen    = 1'b1;
            end
            ST_DECODE: begin
                ctrl.alusrcb = SRCB_IMMSH;
                ctrl.aluop   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.iord = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = MEMW_WORD;
            end
            ST_RTEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                // bne inverts the sense of the ALU zero flag
                ctrl.pcen    = zero ^ (op == OP_BNE);
            end
            ST_ADDIEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl.regwrite = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pcsrc = PCSRC_JUMP;
                ctrl.pcen  = 1'b1;
            end
            ST_MULDIV: begin
                ctrl.md_busy = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS main controller: state register, mult/div latency counter and
// next-state logic; per-state outputs come from mips_mc_outdec.
module mips_mc_controller
    import mips_pkg::*;
#(
    parameter int MULDIV_LAT    = 4,
    parameter int MEM_HANDSHAKE = 1
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] memwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       md_start,
    output logic       md_busy,
    output logic       illegal
);

    localparam logic [5:0] LAT_M1 = 6'(MULDIV_LAT - 1);

    state_t     state_reg, state_next;
    logic [5:0] cnt_reg, cnt_next;
    logic       mem_ok;
    ctrl_t      ctrl;

    assign mem_ok = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        md_start   = 1'b0;
        illegal    = 1'b0;
        case (state_reg)
            ST_FETCH:  if (mem_ok) state_next = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_RTYPE: begin
                        if (is_muldiv(op, funct)) begin
                            state_next = ST_MULDIV;
                            cnt_next   = LAT_M1;
                            md_start   = 1'b1;
                        end else begin
                            state_next = ST_RTEXEC;
                        end
                    end
                    OP_BEQ, OP_BNE: state_next = ST_BRANCH;
                    OP_ADDI:        state_next = ST_ADDIEXEC;
                    OP_J:           state_next = ST_JUMP;
                    default: begin
                        state_next = ST_FETCH;
                        illegal    = 1'b1;
                    end
                endcase
            end
            ST_MEMADR:   state_next = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    if (mem_ok) state_next = ST_MEMWB;
            ST_MEMWB:    state_next = ST_FETCH;
            ST_MEMWR:    if (mem_ok) state_next = ST_FETCH;
            ST_RTEXEC:   state_next = ST_ALUWB;
            ST_ALUWB:    state_next = ST_FETCH;
            ST_BRANCH:   state_next = ST_FETCH;
            ST_ADDIEXEC: state_next = ST_ADDIWB;
            ST_ADDIWB:   state_next = ST_FETCH;
            ST_JUMP:     state_next = ST_FETCH;
            ST_MULDIV: begin
                // counter starts at LAT-1, so reaching 0 marks the last busy cycle
                if (cnt_reg == 6'd0) state_next = ST_FETCH;
                else                 cnt_next   = cnt_reg - 6'd1;
            end
            default:     state_next = ST_FETCH;
        endcase
    end

    mips_mc_outdec u_outdec (
        .state (state_reg),
        .op    (op),
        .zero  (zero),
        .ctrl  (ctrl)
    );

    // Fetch strobes wait for the instruction word and stay quiet while in reset
    assign irwrite  = ctrl.irwrite & mem_ok & ~reset;
    assign pcen     = (state_reg == ST_FETCH) ? (ctrl.pcen & mem_ok & ~reset) : ctrl.pcen;
    assign iord     = ctrl.iord;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign alusrca  = ctrl.alusrca;
    assign memwrite = ctrl.memwrite;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign md_busy  = ctrl.md_busy;

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 4, meaning the number of cycles a mult/div operation occupies (legal range 1..63).
REQ-002 SHALL have parameter MEM_HANDSHAKE, default 1, meaning: 1 = memory states wait on mem_ready; 0 = memory always completes in one cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port op, input, 6 bits: instr[31:26].
REQ-006 SHALL have port funct, input, 6 bits: instr[5:0].
REQ-007 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port mem_ready, input, 1 bit: memory access complete.
REQ-009 SHALL have port pcen, output, 1 bit: PC register enable.
REQ-010 SHALL have outputs iord, irwrite, regdst, memtoreg, regwrite, alusrca, each 1 bit.
REQ-011 SHALL have outputs memwrite [1:0] (00 none, 11 word), alusrcb [1:0] (00 rt, 01 const 4, 10 signext imm, 11 imm<<2), pcsrc [1:0] (00 ALU result, 01 ALUOut, 10 jump target) and aluop [1:0] (00 add, 01 sub, 10 decode funct).
REQ-012 SHALL have outputs md_start (1-cycle pulse), md_busy (1 bit) and illegal (1-cycle pulse on an unknown opcode).

Function
REQ-013 SHALL implement the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP and MULDIV.
REQ-014 FETCH SHALL assert iord=0, alusrca=0, alusrcb=01, aluop=00 and pcsrc=00; with mem_ready high it SHALL also assert irwrite and pcen and move to DECODE, otherwise it SHALL hold.
REQ-015 DECODE SHALL drive alusrcb=11, aluop=00 and then branch on op: 100011/101011 -> MEMADR; 000000 -> MULDIV if funct is 011000 or 011010, else RTEXEC; 000100/000101 -> BRANCH; 001000 -> ADDIEXEC; 000010 -> JUMP; any other op -> FETCH with illegal pulsed.
REQ-016 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=00, then go to MEMRD for lw or MEMWR for sw.
REQ-017 MEMRD SHALL drive iord=1 and hold until mem_ready, then go to MEMWB; MEMWB SHALL drive regwrite=1, memtoreg=1, regdst=0, then go to FETCH.
REQ-018 MEMWR SHALL drive iord=1 and memwrite=11 and hold until mem_ready, then go to FETCH; memwrite SHALL be 00 in every other state.
REQ-019 RTEXEC SHALL drive alusrca=1, alusrcb=00, aluop=10, then go to ALUWB; ALUWB SHALL drive regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsrc=01, with pcen = zero XOR (op==000101), then go to FETCH.
REQ-021 ADDIEXEC SHALL drive alusrca=1, alusrcb=10, aluop=00 and then go to ADDIWB; ADDIWB SHALL drive regwrite=1, regdst=0, then go to FETCH.
REQ-022 JUMP SHALL drive pcsrc=10 and pcen=1, then go to FETCH.
REQ-023 DECODE->MULDIV SHALL pulse md_start for one cycle and load a 6-bit down-counter with MULDIV_LAT-1; MULDIV SHALL hold md_busy=1 and decrement each cycle, and SHALL return to FETCH in the cycle after the counter reads 0, so MULDIV lasts exactly MULDIV_LAT cycles.
REQ-024 Any output not listed for a state SHALL be 0 in that state; all outputs SHALL be decoded combinationally from state and inputs (Moore style, except pcen in BRANCH/FETCH).
REQ-025 With MEM_HANDSHAKE=0, mem_ready SHALL be ignored and treated as 1.
REQ-026 A mem_ready pulse arriving outside FETCH, MEMRD and MEMWR SHALL have no effect.

Reset
REQ-027 reset high SHALL force the state to FETCH and the counter to 0 immediately, independent of clk, including in the middle of MULDIV or a stalled memory state.
REQ-028 While reset is held, the controller SHALL drive all outputs of FETCH except irwrite and pcen, which SHALL be 0, and md_start, md_busy and illegal SHALL be 0.

Structure
REQ-029 The state enum, opcode/funct localparams and the aluop/alusrcb/pcsrc encodings SHALL live in a shared package mips_pkg.
REQ-030 The output decode SHALL be a combinational sub-module mips_mc_outdec (state, op, zero in -> control word out); the state register and counter SHALL stay in the top.

Verification
REQ-031 lw with mem_ready held high -> FETCH, DECODE, MEMADR, MEMRD, MEMWB: 5 cycles, regwrite=1 only in the 5th.
REQ-032 sw with mem_ready low for 3 cycles in MEMWR -> memwrite=11 for 4 cycles, with no other state change.
REQ-033 beq with zero=1 -> pcen=1 in BRANCH; bne with zero=1 -> pcen=0.
REQ-034 mult with MULDIV_LAT=4 -> md_start for 1 cycle, md_busy for 4 cycles, then FETCH; repeat with MULDIV_LAT=1 -> 1 busy cycle.
REQ-035 op=111111 -> illegal pulses once, then FETCH; reset asserted mid-MULDIV -> FETCH asynchronously with md_busy=0.
